// File: rtl/tspi_req_arbiter.sv
// tspi_req_arbiter: round-robin arbiter sharing the TSPI host OBI port
// between NumReq requesters. One transaction in flight at a time. A
// requester can hold ownership across a command sequence with lock_i.
// Optional feature: define TSPI_ARB_LOCK_TIMEOUT_EN to force-release a
// lock after LockTimeout idle cycles.
module tspi_req_arbiter #(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned LockTimeout = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq-1:0]           req_i,
    input  logic [NumReq-1:0]           we_i,
    input  logic [NumReq*AddrWidth-1:0] addr_i,
    input  logic [NumReq*DataWidth-1:0] wdata_i,
    input  logic [NumReq-1:0]           lock_i,
    output logic [NumReq-1:0]           gnt_o,
    output logic [NumReq-1:0]           rvalid_o,
    output logic [DataWidth-1:0]        rdata_o,
    output logic                        err_o,
    output logic                        host_req_o,
    output logic                        host_we_o,
    output logic [AddrWidth-1:0]        host_addr_o,
    output logic [DataWidth-1:0]        host_wdata_o,
    input  logic                        host_gnt_i,
    input  logic                        host_rvalid_i,
    input  logic [DataWidth-1:0]        host_rdata_i,
    input  logic                        host_err_i,
    output logic [$clog2(NumReq)-1:0]   owner_o,
    output logic                        busy_o,
    output logic                        lock_release_o
);

    localparam int unsigned OwnW = $clog2(NumReq);

    // Elaboration-time parameter range checks
    if (NumReq < 2 || NumReq > 8) begin : g_numreq_check
        $error("tspi_req_arbiter: NumReq must be in 2..8");
    end
    if (LockTimeout < 2) begin : g_timeout_check
        $error("tspi_req_arbiter: LockTimeout must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        LOCKED   = 2'd3
    } state_e;

    typedef struct packed {
        logic                 we;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] wdata;
    } txn_t;

    state_e          state_q, state_d;
    logic [OwnW-1:0] owner_q, owner_d;
    logic [OwnW-1:0] rr_q, rr_d;
    txn_t            txn_q, txn_d;

    logic [OwnW-1:0]   sel_idx, cand, lat_idx, next_rr;
    logic              sel_valid, load, rsp_acc;
    logic [NumReq-1:0] owner_oh;

    assign owner_oh     = NumReq'(1) << owner_q;
    assign next_rr      = (owner_q == OwnW'(NumReq - 1)) ? '0 : owner_q + OwnW'(1);
    assign host_we_o    = txn_q.we;
    assign host_addr_o  = txn_q.addr;
    assign host_wdata_o = txn_q.wdata;
    assign owner_o      = owner_q;
    assign busy_o       = (state_q != IDLE);

    // First requester at or after the rr pointer, with wrap-around
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = OwnW'((32'(rr_q) + i) % NumReq);
            if (!sel_valid && req_i[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

`ifdef TSPI_ARB_LOCK_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(LockTimeout);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            release_q, release_d;
    assign lock_release_o = release_q;
`else
    assign lock_release_o = 1'b0;
`endif

    // Next-state, payload latch and host/requester handshake outputs
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        txn_d      = txn_q;
        lat_idx    = owner_q;
        load       = 1'b0;
        rsp_acc    = 1'b0;
        gnt_o      = '0;
        rvalid_o   = '0;
        rdata_o    = '0;
        err_o      = 1'b0;
        host_req_o = 1'b0;
`ifdef TSPI_ARB_LOCK_TIMEOUT_EN
        cnt_d      = '0;
        release_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    owner_d = sel_idx;
                    lat_idx = sel_idx;
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                host_req_o = 1'b1;
                if (host_gnt_i) begin
                    gnt_o = owner_oh;
                    if (host_rvalid_i) begin
                        rsp_acc = 1'b1;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (host_rvalid_i) begin
                    rsp_acc = 1'b1;
                end
            end
            LOCKED: begin
                if (req_i[owner_q]) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end else if (!lock_i[owner_q]) begin
                    rr_d    = next_rr;
                    state_d = IDLE;
                end
`ifdef TSPI_ARB_LOCK_TIMEOUT_EN
                else if (cnt_q == CntW'(LockTimeout - 1)) begin
                    rr_d      = next_rr;
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Response completes the transaction; lock decides who owns next
        if (rsp_acc) begin
            rvalid_o = owner_oh;
            rdata_o  = host_rdata_i;
            err_o    = host_err_i;
            if (lock_i[owner_q]) begin
                state_d = LOCKED;
            end else begin
                rr_d    = next_rr;
                state_d = IDLE;
            end
        end

        if (load) begin
            txn_d.we    = we_i[lat_idx];
            txn_d.addr  = addr_i[32'(lat_idx)*AddrWidth +: AddrWidth];
            txn_d.wdata = wdata_i[32'(lat_idx)*DataWidth +: DataWidth];
        end
    end

    // State, ownership, rr pointer and latched payload registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            txn_q   <= txn_d;
        end
    end

`ifdef TSPI_ARB_LOCK_TIMEOUT_EN
    // Idle-lock counter and force-release pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            release_q <= release_d;
        end
    end
`endif

endmodule

// File: tb/tb_tspi_req_arbiter.sv
// tb_tspi_req_arbiter: directed bench for tspi_req_arbiter (NumReq=2).
// Define TSPI_ARB_LOCK_TIMEOUT_EN to also exercise the forced lock release.
module tb_tspi_req_arbiter;

    localparam int unsigned NumReq = 2;
    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;

    logic                 clk_i;
    logic                 rst_ni;
    logic [NumReq-1:0]    req_i, we_i, lock_i;
    logic [NumReq*AW-1:0] addr_i;
    logic [NumReq*DW-1:0] wdata_i;
    logic [NumReq-1:0]    gnt_o, rvalid_o;
    logic [DW-1:0]        rdata_o;
    logic                 err_o;
    logic                 host_req_o, host_we_o;
    logic [AW-1:0]        host_addr_o;
    logic [DW-1:0]        host_wdata_o;
    logic                 host_gnt_i, host_rvalid_i, host_err_i;
    logic [DW-1:0]        host_rdata_i;
    logic [0:0]           owner_o;
    logic                 busy_o, lock_release_o;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    tspi_req_arbiter #(
        .NumReq     (NumReq),
        .AddrWidth  (AW),
        .DataWidth  (DW),
        .LockTimeout(16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .lock_i        (lock_i),
        .gnt_o         (gnt_o),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .host_req_o    (host_req_o),
        .host_we_o     (host_we_o),
        .host_addr_o   (host_addr_o),
        .host_wdata_o  (host_wdata_o),
        .host_gnt_i    (host_gnt_i),
        .host_rvalid_i (host_rvalid_i),
        .host_rdata_i  (host_rdata_i),
        .host_err_i    (host_err_i),
        .owner_o       (owner_o),
        .busy_o        (busy_o),
        .lock_release_o(lock_release_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered in an ISSUE cycle: grant now, respond next cycle, then one settle cycle
    task automatic txn(input int owner, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic [31:0] rsp, input logic rsp_err);
        logic [1:0] oh;
        oh = 2'(1 << owner);
        host_gnt_i = 1'b1;
        #1;
        chk("issue_host_req", 32'(host_req_o), 32'd1);
        chk("issue_gnt", 32'(gnt_o), 32'(oh));
        chk("issue_owner", 32'(owner_o), 32'(owner));
        chk("issue_host_addr", host_addr_o, exp_addr);
        chk("issue_host_wdata", host_wdata_o, exp_wdata);
        tick();
        host_gnt_i    = 1'b0;
        host_rvalid_i = 1'b1;
        host_rdata_i  = rsp;
        host_err_i    = rsp_err;
        #1;
        chk("wait_host_req_low", 32'(host_req_o), 32'd0);
        chk("rsp_rvalid", 32'(rvalid_o), 32'(oh));
        chk("rsp_rdata", rdata_o, rsp);
        chk("rsp_err", 32'(err_o), 32'(rsp_err));
        tick();
        host_rvalid_i = 1'b0;
        host_err_i    = 1'b0;
        host_rdata_i  = 32'hFFFF_0000;
        #1;
        chk("post_rvalid_clr", 32'(rvalid_o), 32'd0);
        chk("post_err_clr", 32'(err_o), 32'd0);
        chk("post_rdata_zero", rdata_o, 32'd0);
    endtask

    initial begin
        rst_ni        = 1'b0;
        req_i         = '0;
        we_i          = '0;
        lock_i        = '0;
        addr_i        = '0;
        wdata_i       = '0;
        host_gnt_i    = 1'b0;
        host_rvalid_i = 1'b0;
        host_err_i    = 1'b0;
        host_rdata_i  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_host_req", 32'(host_req_o), 32'd0);
        chk("rst_host_addr", host_addr_o, 32'd0);
        chk("rst_owner", 32'(owner_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_lock_release", 32'(lock_release_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // Fairness: both requesting, owners alternate 0,1,0,1 from rr=0
        req_i   = 2'b11;
        addr_i  = {32'h200, 32'h100};
        wdata_i = {32'hB1B1, 32'hA0A0};
        tick();
        txn(0, 32'h100, 32'hA0A0, 32'h1000, 1'b0);
        tick();
        txn(1, 32'h200, 32'hB1B1, 32'h1001, 1'b0);
        tick();
        txn(0, 32'h100, 32'hA0A0, 32'h1002, 1'b0);
        tick();
        txn(1, 32'h200, 32'hB1B1, 32'h1003, 1'b0);
        req_i = 2'b00;
        #1;
        chk("fair_idle_busy", 32'(busy_o), 32'd0);

        // Single request, host grant on the third ISSUE cycle, response three cycles later
        tick();
        req_i   = 2'b01;
        we_i    = 2'b01;
        addr_i  = '0;
        wdata_i = {32'h0, 32'h19};
        tick();
        chk("single_host_req", 32'(host_req_o), 32'd1);
        chk("single_host_we", 32'(host_we_o), 32'd1);
        chk("single_host_addr", host_addr_o, 32'h0);
        chk("single_host_wdata", host_wdata_o, 32'h19);
        chk("single_busy", 32'(busy_o), 32'd1);
        chk("single_gnt_before", 32'(gnt_o), 32'd0);
        tick();
        chk("single_hold_req", 32'(host_req_o), 32'd1);
        tick();
        host_gnt_i = 1'b1;
        #1;
        chk("single_gnt", 32'(gnt_o), 32'b01);
        req_i = 2'b00;
        tick();
        host_gnt_i = 1'b0;
        #1;
        chk("single_wait_host_req", 32'(host_req_o), 32'd0);
        chk("single_wait_gnt", 32'(gnt_o), 32'd0);
        tick();
        tick();
        host_rvalid_i = 1'b1;
        host_rdata_i  = 32'h5A5A;
        #1;
        chk("single_rvalid", 32'(rvalid_o), 32'b01);
        chk("single_rdata", rdata_o, 32'h5A5A);
        tick();
        host_rvalid_i = 1'b0;
        #1;
        chk("single_busy_done", 32'(busy_o), 32'd0);
        chk("single_rvalid_done", 32'(rvalid_o), 32'd0);

        // Lock: requester 1 (rr=1) does three locked writes while requester 0 waits
        req_i   = 2'b11;
        we_i    = 2'b11;
        lock_i  = 2'b10;
        addr_i  = {32'hB0, 32'hA0};
        wdata_i = {32'h11, 32'h0A};
        tick();
        txn(1, 32'hB0, 32'h11, 32'h2001, 1'b0);
        chk("lock_busy", 32'(busy_o), 32'd1);
        chk("lock_owner", 32'(owner_o), 32'd1);
        wdata_i = {32'h22, 32'h0A};
        tick();
        txn(1, 32'hB0, 32'h22, 32'h2002, 1'b0);
        wdata_i = {32'h33, 32'h0A};
        tick();
        txn(1, 32'hB0, 32'h33, 32'h2003, 1'b0);
        req_i = 2'b01;
        tick();
        chk("lock_hold_busy", 32'(busy_o), 32'd1);
        chk("lock_hold_host_req", 32'(host_req_o), 32'd0);
        tick();
        chk("lock_hold_owner", 32'(owner_o), 32'd1);
        lock_i = 2'b00;
        tick();
        chk("unlock_idle", 32'(busy_o), 32'd0);
        tick();
        txn(0, 32'hA0, 32'h0A, 32'h2004, 1'b0);
        req_i = 2'b00;

        // Same-cycle grant and response (owner 1), then error response to owner 0
        tick();
        req_i   = 2'b11;
        addr_i  = {32'hC0, 32'hD0};
        wdata_i = {32'h44, 32'h55};
        tick();
        host_gnt_i    = 1'b1;
        host_rvalid_i = 1'b1;
        host_rdata_i  = 32'hDEADBEEF;
        #1;
        chk("same_gnt", 32'(gnt_o), 32'b10);
        chk("same_rvalid", 32'(rvalid_o), 32'b10);
        chk("same_rdata", rdata_o, 32'hDEADBEEF);
        chk("same_host_addr", host_addr_o, 32'hC0);
        tick();
        host_gnt_i    = 1'b0;
        host_rvalid_i = 1'b0;
        #1;
        chk("same_idle", 32'(busy_o), 32'd0);
        chk("same_rvalid_clr", 32'(rvalid_o), 32'd0);
        tick();
        txn(0, 32'hD0, 32'h55, 32'hE0E0, 1'b1);
        req_i = 2'b00;

        // Reset while waiting for a response (owner 1)
        tick();
        req_i   = 2'b10;
        addr_i  = {32'h1C, 32'h0};
        wdata_i = {32'h77, 32'h0};
        tick();
        host_gnt_i = 1'b1;
        tick();
        host_gnt_i = 1'b0;
        #1;
        chk("wrst_busy_before", 32'(busy_o), 32'd1);
        chk("wrst_owner_before", 32'(owner_o), 32'd1);
        rst_ni        = 1'b0;
        host_rvalid_i = 1'b1;
        host_rdata_i  = 32'h55;
        #1;
        chk("wrst_busy", 32'(busy_o), 32'd0);
        chk("wrst_owner", 32'(owner_o), 32'd0);
        chk("wrst_rvalid", 32'(rvalid_o), 32'd0);
        chk("wrst_rdata", rdata_o, 32'd0);
        chk("wrst_host_req", 32'(host_req_o), 32'd0);
        chk("wrst_host_addr", host_addr_o, 32'd0);
        chk("wrst_host_wdata", host_wdata_o, 32'd0);
        host_rvalid_i = 1'b0;
        req_i         = 2'b00;
        tick();
        rst_ni = 1'b1;
        tick();

`ifdef TSPI_ARB_LOCK_TIMEOUT_EN
        // Locked owner 1 idles 16 cycles: forced release, requester 0 granted
        req_i   = 2'b10;
        lock_i  = 2'b10;
        addr_i  = {32'hE0, 32'hF0};
        wdata_i = {32'h66, 32'h88};
        tick();
        txn(1, 32'hE0, 32'h66, 32'h3001, 1'b0);
        req_i = 2'b01;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("to_still_locked", 32'(busy_o), 32'd1);
        chk("to_no_release_yet", 32'(lock_release_o), 32'd0);
        tick();
        chk("to_release_pulse", 32'(lock_release_o), 32'd1);
        chk("to_idle", 32'(busy_o), 32'd0);
        tick();
        chk("to_release_single", 32'(lock_release_o), 32'd0);
        lock_i = 2'b00;
        txn(0, 32'hF0, 32'h88, 32'h3002, 1'b0);
        req_i = 2'b00;
`else
        chk("no_timeout_release_tied", 32'(lock_release_o), 32'd0);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tspi_req_arbiter.md
Name: tspi_req_arbiter

Overview:
- Shares the single OBI subordinate port of the TSPI host controller between NumReq requesters, for example the CPU and a block-swap DMA engine.
- Round-robin arbitration. One outstanding transaction at a time.
- Optional per-requester lock keeps ownership across a multi-command SPI sequence (configure, then data words, then done poll) so that another requester cannot interleave commands.
- Sits between the user-domain crossbar or requesters and the TSPI host OBI port.

Parameters:
- NumReq, 2, number of requesters; range 2..8.
- AddrWidth, 32, OBI address width.
- DataWidth, 32, OBI data width.
- LockTimeout, 1024, idle cycles before a forced lock release; used only when the optional feature is enabled.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NumReq  per-requester request.
- we_i  in  NumReq  per-requester write enable.
- addr_i  in  NumReq*AddrWidth  per-requester address.
- wdata_i  in  NumReq*DataWidth  per-requester write data.
- lock_i  in  NumReq  requester keeps ownership after its current transaction.
- gnt_o  out  NumReq  per-requester grant (one-hot or zero).
- rvalid_o  out  NumReq  per-requester response valid (one-hot or zero).
- rdata_o  out  DataWidth  response data, shared by all requesters.
- err_o  out  1  response error, qualified by rvalid_o.
- host_req_o  out  1  request to the TSPI host.
- host_we_o  out  1  write enable to the host.
- host_addr_o  out  AddrWidth  address to the host.
- host_wdata_o  out  DataWidth  write data to the host.
- host_gnt_i  in  1  host grant.
- host_rvalid_i  in  1  host response valid.
- host_rdata_i  in  DataWidth  host response data.
- host_err_i  in  1  host response error.
- owner_o  out  $clog2(NumReq)  index of the current or last owner.
- busy_o  out  1  high in any state other than IDLE.
- lock_release_o  out  1  single-cycle pulse when a lock is force-released (feature only).

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer 0, timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT_RSP, LOCKED.

IDLE:
- If any req_i bit is high, select the first requesting index at or after the rr pointer, with wrap-around.
- Latch owner, we, addr and wdata into registers, then go to ISSUE.
- Selection adds one cycle of latency; host_req_o rises the cycle after req_i is sampled.

ISSUE:
- host_req_o = 1, driving the latched fields.
- The host_gnt_i cycle itself: gnt_o[owner] = 1 (combinational pass-through of host_gnt_i).
- Next state: WAIT_RSP.
- Latched fields hold stable until the grant; requesters must hold req and payload until gnt_o.

WAIT_RSP:
- On host_rvalid_i: rvalid_o[owner] = 1 in the same cycle; rdata_o = host_rdata_i; err_o = host_err_i.
- Ownership decision uses lock_i[owner] sampled in the rvalid cycle:
  - If set, go to LOCKED.
  - Else advance the rr pointer to owner+1 (mod NumReq) and go to IDLE.
- If host_rvalid_i arrives in the same cycle as host_gnt_i while in ISSUE, go straight to the WAIT_RSP exit handling. No response may be lost.

LOCKED:
- Only req_i[owner] is honoured; it is latched and the FSM goes to ISSUE.
- If lock_i[owner] falls with no req_i[owner]: advance the rr pointer and go to IDLE.
- Other requesters are stalled; their gnt_o stays 0.

General rules:
- At most one outstanding host transaction. host_req_o is never high in WAIT_RSP.
- gnt_o and rvalid_o are never asserted for a non-owner.
- rdata_o is 0 when no rvalid_o bit is set.
- A requester dropping req_i before its grant is a protocol violation. The arbiter completes the latched transaction anyway and discards the response (rvalid_o still pulses to the owner).
- Reset mid-operation: immediate return to IDLE with all outputs 0. A host transaction still in flight is abandoned; the host is reset in the same domain.

Optional Feature:
- Macro: TSPI_ARB_LOCK_TIMEOUT_EN.
- With the macro:
  - The counter counts cycles in LOCKED with req_i[owner] low; any owner request clears it.
  - When the count reaches LockTimeout-1: force a transition to IDLE, advance the rr pointer, and pulse lock_release_o for one cycle.
  - The owner must deassert lock_i and re-arbitrate.
- Without the macro: the lock is held indefinitely, lock_release_o is tied to 0, and no counter is instantiated.

Test Plan:
- Single request: req_i=01, we=1, addr=0x0, wdata=0x19; host_gnt_i after 2 cycles, rvalid 3 cycles later -> host_addr_o=0x0, host_wdata_o=0x19, gnt_o=01 in the host-grant cycle, rvalid_o=01, busy_o returns 0.
- Fairness: req_i=11 held continuously, host grants immediately, rvalid 1 cycle later -> owners alternate 0,1,0,1 over 4 transactions; neither requester starves.
- Lock: requester 1 issues 3 writes with lock_i[1]=1 while req_i[0]=1 throughout -> gnt_o[0]=0 until requester 1 drops lock_i; requester 0 is granted next.
- Same-cycle gnt and rvalid: host_gnt_i and host_rvalid_i high together, host_rdata_i=0xDEADBEEF -> rvalid_o[owner]=1 with rdata_o=0xDEADBEEF in that cycle; next request is issued with no lost response.
- Error propagation: host_err_i=1 with rvalid -> err_o=1 for exactly one cycle, only to the owner.
- Reset in WAIT_RSP, plus (with TSPI_ARB_LOCK_TIMEOUT_EN, LockTimeout=16) locked owner idle for 16 cycles:
  - Reset in WAIT_RSP -> all outputs 0 immediately.
  - Locked owner idle 16 cycles -> lock_release_o pulses once and the other requester is granted.
